// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, types and the hex-to-segment pattern table for
// the seven-segment display blocks.
//   NUM_DIGITS   number of multiplexed digits on the board
//   SEG_BLANK    active-low pattern with every segment off
//   digit_idx_t  index of the currently scanned digit
//   hexToSeg7    nibble -> active-low {g,f,e,d,c,b,a} pattern
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef logic [1:0] digit_idx_t;

  function automatic logic [6:0] hexToSeg7(input logic [3:0] nibble);
    logic [6:0] pattern;
    case (nibble)
      4'h0: pattern = 7'b1000000;
      4'h1: pattern = 7'b1111001;
      4'h2: pattern = 7'b0100100;
      4'h3: pattern = 7'b0110000;
      4'h4: pattern = 7'b0011001;
      4'h5: pattern = 7'b0010010;
      4'h6: pattern = 7'b0000010;
      4'h7: pattern = 7'b1111000;
      4'h8: pattern = 7'b0000000;
      4'h9: pattern = 7'b0010000;
      4'hA: pattern = 7'b0001000;
      4'hB: pattern = 7'b0000011;
      4'hC: pattern = 7'b1000110;
      4'hD: pattern = 7'b0100001;
      4'hE: pattern = 7'b0000110;
      default: pattern = 7'b0001110;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: bundles the display request side (value, hold, blanking,
// decimal points) with the board-facing pin side (anodes, segments, dp).
//   master  drives value/hold/blank_lz/dp_in, observes an/seg/dp
//   slave   the scan controller: consumes the requests, drives the pins
interface seg7_scan_ctrl_if;
  import seg7_pkg::*;

  logic [15:0]           value;
  logic                  hold;
  logic                  blank_lz;
  logic [NUM_DIGITS-1:0] dp_in;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;
  logic                  dp;

  modport master (
    output value, hold, blank_lz, dp_in,
    input  an, seg, dp
  );

  modport slave (
    input  value, hold, blank_lz, dp_in,
    output an, seg, dp
  );

endinterface

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: purely combinational decode of one hex nibble into the
// active-low {g,f,e,d,c,b,a} segment pattern of a common-anode display.
//   nibble_i  hex digit to show
//   seg_o     active-low segment pattern
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hexToSeg7(nibble_i);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexes a 16-bit hex value onto a 4-digit
// common-anode display. Each digit is lit for REFRESH_DIV cycles; the value is
// snapshotted once per frame so all four digits show the same count.
//   clock, reset  system clock and synchronous active-high reset
//   bus.value     hex value to display, digit k = value[4k+3:4k]
//   bus.hold      freeze the snapshot at the next frame start
//   bus.blank_lz  blank leading-zero digits 3..1
//   bus.dp_in     active-high decimal point request per digit
//   bus.an        active-low anode enables
//   bus.seg       active-low segments {g,f,e,d,c,b,a}
//   bus.dp        active-low decimal point of the lit digit
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input logic        clock,
  input logic        reset,
  seg7_scan_ctrl_if.slave bus
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  digit_idx_t       idx_q, idx_d;
  logic             started_q, started_d;
  logic [15:0]      snap_q, snap_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic       tick;
  logic       frameStart;
  logic       blanked;
  logic [3:0] nibble;
  logic [6:0] decoded;

  // Prescaler, digit sequencing and snapshot. The very first tick after reset
  // is treated as a frame start so the display begins at digit 0 with a fresh
  // snapshot. Nibble select and blanking look at the next-state index/snapshot
  // so the outputs registered on a tick match the digit being entered.
  always_comb begin
    tick       = (pre_q == PRE_LAST);
    pre_d      = tick ? '0 : pre_q + PRE_W'(1);
    frameStart = !started_q || (idx_q == 2'd3);
    idx_d      = idx_q;
    started_d  = started_q;
    snap_d     = snap_q;
    if (tick) begin
      if (frameStart) begin
        idx_d     = '0;
        started_d = 1'b1;
        if (!bus.hold) begin
          snap_d = bus.value;
        end
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end

    case (idx_d)
      2'd0:    nibble = snap_d[3:0];
      2'd1:    nibble = snap_d[7:4];
      2'd2:    nibble = snap_d[11:8];
      default: nibble = snap_d[15:12];
    endcase

    // Digit k is a leading zero when nibbles k..3 are all zero.
    case (idx_d)
      2'd0:    blanked = 1'b0;
      2'd1:    blanked = bus.blank_lz && (snap_d[15:4] == 12'h000);
      2'd2:    blanked = bus.blank_lz && (snap_d[15:8] == 8'h00);
      default: blanked = bus.blank_lz && (snap_d[15:12] == 4'h0);
    endcase
  end

  hex_to_seg7 u_decode (
    .nibble_i (nibble),
    .seg_o    (decoded)
  );

  // Pin outputs only change on a tick; a blanked slot still takes its time.
  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    if (tick) begin
      if (blanked) begin
        an_d  = 4'hF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
      end else begin
        an_d  = ~(4'b0001 << idx_d);
        seg_d = decoded;
        dp_d  = ~bus.dp_in[idx_d];
      end
    end
  end

  // State and output registers with synchronous reset to a dark display.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q     <= '0;
      idx_q     <= '0;
      started_q <= 1'b0;
      snap_q    <= '0;
      an_q      <= 4'hF;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      started_q <= started_d;
      snap_q    <= snap_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexing controller that drives a 4-digit common-anode seven-segment display from the 16-bit `count` produced by the `counter` block. It scans one hex digit at a time at a parameterised refresh rate and snapshots the value once per frame so all four digits always show the same count. It also supports leading-zero blanking, per-digit decimal points and a display-hold input. It sits between the `counter` datapath and the board's anode/segment pins.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit is lit; legal range ≥ 2.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `value`  in  16  hex value to display (connect to `counter.count`); digit k = `value[4k+3:4k]`.
- `hold`  in  1  1 = keep the current snapshot and ignore `value` at frame start.
- `blank_lz`  in  1  1 = blank leading zero digits 3..1.
- `dp_in`  in  4  active-high decimal point request per digit; bit k = digit k.
- `an`  out  4  active-low anode enables; bit k = digit k.
- `seg`  out  7  active-low segments `{g,f,e,d,c,b,a}`.
- `dp`  out  1  active-low decimal point for the lit digit.

## Operation
- Prescaler `pre` counts 0..`REFRESH_DIV`-1 and wraps. `tick` = (`pre` == `REFRESH_DIV`-1).
- Digit index `idx` (2 bits) plus `started` flag. On `tick`:
  - If `!started` or `idx`==3: `idx`←0, `started`←1, and `snap`←`value` unless `hold`=1.
  - Otherwise `idx`←`idx`+1.
- Outputs are registered and updated only on `tick`, from the new `idx` and new `snap`. When `snap` is loading on that tick, use `value` directly.
  - `an`: all ones except bit `idx` = 0.
  - `seg`: decode of the selected nibble. Patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - `dp` = ~`dp_in[idx]`.
- Leading-zero blanking: with `blank_lz`=1, digit k ≥ 1 is blanked when nibbles k..3 of `snap` are all zero. Blanked means `an[k]`=1, `seg`=1111111, `dp`=1, and the slot time is still consumed. Digit 0 is never blanked.
- `dp_in` and `blank_lz` are sampled at each `tick`, not at snapshot time.
- `hold` is sampled only at frame start. Asserting `hold` mid-frame has no effect until the next frame boundary.

## Timing
- Reset values: `pre`=0, `idx`=0, `started`=0, `snap`=0, `an`=1111, `seg`=1111111, `dp`=1. The display is dark until the first tick.
- First tick occurs on the `REFRESH_DIV`th rising edge after `reset` is released. From the next cycle, digit 0 shows `value` as sampled on that edge.
- Each digit is lit for exactly `REFRESH_DIV` cycles. A frame is 4×`REFRESH_DIV` cycles; the snapshot period equals the frame period.
- Latency from a `value` change to its display: at most 4×`REFRESH_DIV`+1 cycles.
- Reset asserted mid-frame takes effect on the next edge and returns every register to its reset value. The next frame restarts from digit 0 with a fresh snapshot.
- Exactly one `an` bit is low at any time after the first tick, or none if that slot is blanked. There is never a cycle with two digits lit.

## Structure
- Package `seg7_pkg`:
  - `NUM_DIGITS`=4.
  - `SEG_BLANK`=7'b1111111.
  - the 16-entry segment pattern constant/function.
  - `digit_idx_t` (2-bit).
- Sub-module `hex_to_seg7` (combinational nibble to active-low segment decode) is shared with other display blocks. Everything else stays in `seg7_scan_ctrl`.
- Prescaler width is `$clog2(REFRESH_DIV)`.

## Test plan
Run with `REFRESH_DIV`=4.
- Reset: hold `reset` for 5 cycles -> `an`=1111, `seg`=1111111, `dp`=1 throughout, and still 3 cycles after release. Cycle 4 after release -> `an`=1110.
- Scan: `value`=16'h1234, `blank_lz`=0 -> `an` sequence 1110/1101/1011/0111, 4 cycles each. Matching `seg` = 0011001 ("4"), 0110000 ("3"), 0100100 ("2"), 1111001 ("1"). Then repeats.
- Snapshot coherence: change `value` from 16'h1234 to 16'hABCD while digit 1 is lit -> digits 2 and 3 still show 2 and 1. The next frame shows D, C, b, A.
- Blanking: `value`=16'h0050, `blank_lz`=1 -> digits 3 and 2 blanked (`an` all ones, `seg`=1111111 for those slots). Digit 1 shows "5" and digit 0 shows "0". With `value`=16'h0000, only digit 0 is lit, showing "0".
- Hold and dp: `hold`=1 with `value`=16'h00FF then `value`=16'h1111 -> display remains FF across 3 frames. `dp_in`=4'b0100 -> `dp`=0 only while `an`=1011.
- Mid-frame reset: assert `reset` while digit 2 is lit -> next cycle outputs dark. Restart at digit 0 four cycles after release.
